// File: rtl/imm_extend_pipe.sv
// RV decode immediate generator feeding a 2-entry FIFO output buffer.
// Optional IMM_AUTO_DECODE_EN derives the format from the opcode instead of in_imm_src.
module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_Z   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [2:0]      fmt_s;
    logic [31:0]     imm32_s;
    logic            err_s;
    logic [XLEN-1:0] imm_s;
    logic            push_s;
    logic            pop_s;
    state_e          state_q;
    state_e          state_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [XLEN:0]   mem_q [2];
    logic [XLEN:0]   head_s;

`ifdef IMM_AUTO_DECODE_EN
    logic unused_src_s;
    assign unused_src_s = ^in_imm_src;

    // Format from the major opcode; SYSTEM splits CSR immediate forms on funct3[2].
    always_comb begin
        fmt_s = FMT_ILL;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: fmt_s = FMT_I;
            7'b0100011:                         fmt_s = FMT_S;
            7'b1100011:                         fmt_s = FMT_B;
            7'b0110111, 7'b0010111:             fmt_s = FMT_U;
            7'b1101111:                         fmt_s = FMT_J;
            7'b1110011: begin
                if (in_instr[14]) begin
                    fmt_s = FMT_Z;
                end else begin
                    fmt_s = FMT_I;
                end
            end
            default:                            fmt_s = FMT_ILL;
        endcase
    end
`else
    logic unused_opcode_s;
    assign unused_opcode_s = ^in_instr[6:0];
    assign fmt_s = in_imm_src;
`endif

    // 32-bit immediate assembly; every signed format sign-extends from instr[31].
    always_comb begin
        imm32_s = 32'd0;
        err_s   = 1'b0;
        case (fmt_s)
            FMT_I: imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32_s = {in_instr[31:12], 12'd0};
            FMT_J: imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z: imm32_s = {27'd0, in_instr[19:15]};
            default: begin
                imm32_s = 32'd0;
                err_s   = 1'b1;
            end
        endcase
    end

    // Z immediates have bit 31 clear, so replicating bit 31 is correct for every format.
    if (XLEN == 64) begin : g_xlen64
        assign imm_s = {{32{imm32_s[31]}}, imm32_s};
    end else begin : g_xlen32
        assign imm_s = imm32_s;
    end

    assign push_s = in_valid && in_ready_q && !flush;
    assign pop_s  = out_valid_q && out_ready && !flush;

    // Occupancy next-state; flush wins over any transfer.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: state_d = push_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (push_s && !pop_s) begin
                        state_d = ST_FULL;
                    end else if (pop_s && !push_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL:  state_d = pop_s ? ST_ONE : ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // State, handshake flags, pointers and storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_q        <= ~wr_ptr_q;
                    mem_q[wr_ptr_q] <= {imm_s, err_s};
                end
                if (pop_s) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign head_s    = mem_q[rd_ptr_q];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_valid_q ? head_s[XLEN:1] : {XLEN{1'b0}};
    assign out_err   = out_valid_q & head_s[0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench driving an XLEN=32 and an XLEN=64 instance with identical stimulus.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic        rdy32, rdy64, ov32, ov64, err32, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;

    int checks = 0;
    int errors = 0;
    logic [64:0] sb [$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_imm_src(in_imm_src),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_err(err32)
    );

    imm_extend_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_imm_src(in_imm_src),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_err(err64)
    );

    // Reference model: returns {err, 64-bit immediate}
    function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
        logic [2:0]  f;
        logic [63:0] v;
        logic        e;
        f = src;
`ifdef IMM_AUTO_DECODE_EN
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: f = 3'd0;
            7'h23:               f = 3'd1;
            7'h63:               f = 3'd2;
            7'h37, 7'h17:        f = 3'd3;
            7'h6F:               f = 3'd4;
            7'h73:               f = ins[14] ? 3'd5 : 3'd0;
            default:             f = 3'd7;
        endcase
`endif
        e = 1'b0;
        v = 64'd0;
        case (f)
            3'd0: v = 64'($signed(ins[31:20]));
            3'd1: v = 64'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = 64'($signed({ins[31:12], 12'h000}));
            3'd4: v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd5: v = {59'd0, ins[19:15]};
            default: e = 1'b1;
        endcase
        return {e, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [64:0] h;
        h = (sb.size() != 0) ? sb[0] : 65'd0;
        chk({tag, ".in_ready32"},  64'(rdy32), 64'(sb.size() < 2));
        chk({tag, ".in_ready64"},  64'(rdy64), 64'(sb.size() < 2));
        chk({tag, ".out_valid32"}, 64'(ov32),  64'(sb.size() != 0));
        chk({tag, ".out_valid64"}, 64'(ov64),  64'(sb.size() != 0));
        chk({tag, ".imm32"}, {32'd0, imm32}, {32'd0, h[31:0]});
        chk({tag, ".imm64"}, imm64, h[63:0]);
        chk({tag, ".err32"}, 64'(err32), 64'(h[64]));
        chk({tag, ".err64"}, 64'(err64), 64'(h[64]));
    endtask

    // One clock of stimulus: check current outputs, drive inputs, update the model at the edge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [2:0] src, input logic rdy, input logic fl);
        bit push, pop;
        @(negedge clk);
        check_outputs(tag);
        in_valid   = v;
        in_instr   = ins;
        in_imm_src = src;
        out_ready  = rdy;
        flush      = fl;
        push = v && (sb.size() < 2) && !fl;
        pop  = (sb.size() != 0) && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back(ref_imm(ins, src));
        end
    endtask

    // Direct constant check of the head just after an edge
    task automatic expect_head(input string tag, input logic [63:0] imm, input logic err);
        #1;
        chk({tag, ".valid"}, 64'(ov64), 64'd1);
        chk({tag, ".imm64"}, imm64, imm);
        chk({tag, ".imm32"}, {32'd0, imm32}, {32'd0, imm[31:0]});
        chk({tag, ".err"},   64'(err64), 64'(err));
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_instr   = 32'd0;
        in_imm_src = 3'd0;
        #12;
        check_outputs("reset");
        rst_n = 1'b1;

`ifdef IMM_AUTO_DECODE_EN
        step("auto_j", 1'b1, 32'h0000006F, 3'd0, 1'b1, 1'b0);
        expect_head("auto_j_k", 64'd0, 1'b0);
        step("auto_ill", 1'b1, 32'h0000007F, 3'd0, 1'b1, 1'b0);
        expect_head("auto_ill_k", 64'd0, 1'b1);
`else
        step("i", 1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        expect_head("i_k", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step("s", 1'b1, 32'hFE20AE23, 3'd1, 1'b1, 1'b0);
        expect_head("s_k", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step("u", 1'b1, 32'h800000B7, 3'd3, 1'b1, 1'b0);
        expect_head("u_k", 64'hFFFF_FFFF_8000_0000, 1'b0);
        step("z", 1'b1, 32'h000FA073, 3'd5, 1'b1, 1'b0);
        expect_head("z_k", 64'h0000_0000_0000_001F, 1'b0);
        step("ill", 1'b1, 32'h000FA073, 3'd6, 1'b1, 1'b0);
        expect_head("ill_k", 64'd0, 1'b1);
        step("b", 1'b1, 32'h8000_0F80, 3'd2, 1'b1, 1'b0);
        step("j", 1'b1, 32'h8010_0000, 3'd4, 1'b1, 1'b0);
        step("ill7", 1'b1, 32'h1234_5678, 3'd7, 1'b1, 1'b0);
`endif
        step("drain", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Back-pressure: A and B fill the buffer, C is refused while full
        step("bp_a", 1'b1, 32'hABCD_E013, 3'd0, 1'b0, 1'b0);
        step("bp_b", 1'b1, 32'h8765_4323, 3'd1, 1'b0, 1'b0);
        #1;
        chk("bp_full_ready", 64'(rdy64), 64'd0);
        step("bp_c", 1'b1, 32'h1111_1117, 3'd3, 1'b0, 1'b0);
        step("bp_pop1", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        #1;
        chk("bp_ready_back", 64'(rdy32), 64'd1);
        step("bp_pop2", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        step("bp_done", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Flush while full with a simultaneous offer
        step("fl_a", 1'b1, 32'hFFFF_F06F, 3'd4, 1'b0, 1'b0);
        step("fl_b", 1'b1, 32'h0000_8073, 3'd5, 1'b0, 1'b0);
        step("fl_go", 1'b1, 32'h7FF0_0013, 3'd0, 1'b0, 1'b1);
        #1;
        chk("flush_valid", 64'(ov64), 64'd0);
        chk("flush_ready", 64'(rdy64), 64'd1);
        step("fl_after", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        step("rs_a", 1'b1, 32'hF000_0037, 3'd3, 1'b0, 1'b0);
        step("rs_b", 1'b1, 32'h0123_4563, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ov64), 64'd0);
        chk("arst_ready", 64'(rdy32), 64'd1);
        chk("arst_imm",   imm64, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional flushes
        for (int i = 0; i < 60; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step("tail", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        step("tail2", 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
